// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply / divide unit placed behind the register
// file read ports. One bit of the operation is processed per cycle, so an
// accepted MUL/DIV/MOD holds `busy` for ITER cycles. The result then appears
// together with a one-cycle `done`/`we` pulse that drives the register file
// write port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, op, a, b,    request; sampled only while IDLE or DONE
//   dst                 destination register index
//   busy                high while iterating (RUN)
//   done                one-cycle pulse, result valid
//   result, wa          result and write address, held between ops
//   we                  write enable; suppressed for bypassed ops and wa >= 11
//   err                 pulses with done on divide-by-zero / unsupported op
//
// Build option
//   MUL_DIV_UNIT_DIV_EN  when defined, the restoring divider (DIV/MOD) is
//                        present. When undefined, ops 01/10 finish like the
//                        reserved op 11: result 0, err 1, no write.
//
// ITER must equal WIDTH.
module mul_div_unit #(
  parameter int WIDTH = 24,
  parameter int ITER  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       dst,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             we,
  output logic [3:0]       wa,
  output logic             err
);

  localparam int            CW       = $clog2(ITER);
  localparam logic [CW-1:0] LAST     = CW'(ITER - 1);
  localparam logic [1:0]    OP_MUL   = 2'b00;
  localparam logic [1:0]    OP_DIV   = 2'b01;
  localparam logic [1:0]    OP_MOD   = 2'b10;
  localparam logic [3:0]    WA_LIMIT = 4'd11;  // 11 is the PC alias, 12..15 do not exist

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;      // MUL: shifting multiplicand; DIV: dividend -> quotient
  logic [WIDTH-1:0] opb_q, opb_d;      // MUL: shifting multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc_q, acc_d;      // MUL partial product
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       dst_q, dst_d;
  logic [3:0]       wa_q, wa_d;
  logic             err_q, err_d;
  logic             byp_q, byp_d;      // op finished without a write
`ifdef MUL_DIV_UNIT_DIV_EN
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH:0]   rem_sh;
`endif

  logic accept;
  logic fast;   // op goes straight to DONE
  logic dz;     // divide by zero on an implemented divide op

  assign accept = start && (state_q == IDLE || state_q == DONE);

`ifdef MUL_DIV_UNIT_DIV_EN
  assign fast = (op == 2'b11);
  assign dz   = (op == OP_DIV || op == OP_MOD) && (b == '0);
`else
  assign fast = (op != OP_MUL);
  assign dz   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      dst_q    <= '0;
      wa_q     <= '0;
      err_q    <= 1'b0;
      byp_q    <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      dst_q    <= dst_d;
      wa_q     <= wa_d;
      err_q    <= err_d;
      byp_q    <= byp_d;
`ifdef MUL_DIV_UNIT_DIV_EN
      rem_q    <= rem_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = fast ? DONE : RUN;
        else       state_d = IDLE;
      end
      RUN:     if (cnt_q == LAST) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    dst_d    = dst_q;
    wa_d     = wa_q;
    err_d    = err_q;
    byp_d    = byp_q;
`ifdef MUL_DIV_UNIT_DIV_EN
    rem_d    = rem_q;
    rem_sh   = {rem_q[WIDTH-1:0], opa_q[WIDTH-1]};
`endif
    if (accept) begin
      cnt_d = '0;
      op_d  = op;
      opa_d = a;
      opb_d = b;
      acc_d = '0;
      dst_d = dst;
      err_d = fast || dz;
      byp_d = fast;
`ifdef MUL_DIV_UNIT_DIV_EN
      rem_d = '0;
`endif
      // Bypassed ops publish their (zero) result right away.
      if (fast) begin
        result_d = '0;
        wa_d     = dst;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (op_q == OP_MUL) begin
        if (opb_q[0]) acc_d = acc_q + opa_q;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end
`ifdef MUL_DIV_UNIT_DIV_EN
      else begin
        // Restoring step. With b == 0 every step subtracts, so the quotient
        // fills with ones and the remainder ends up equal to the dividend.
        if (rem_sh >= {1'b0, opb_q}) begin
          rem_d = rem_sh - {1'b0, opb_q};
          opa_d = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end
      end
`endif
      if (cnt_q == LAST) begin
        wa_d = dst_q;
`ifdef MUL_DIV_UNIT_DIV_EN
        case (op_q)
          OP_DIV:  result_d = opa_d;
          OP_MOD:  result_d = rem_d[WIDTH-1:0];
          default: result_d = acc_d;
        endcase
`else
        result_d = acc_d;
`endif
      end
    end
  end

  // Outputs
  always_comb begin
    busy   = (state_q == RUN);
    done   = (state_q == DONE);
    err    = done && err_q;
    we     = done && !byp_q && (wa_q < WA_LIMIT);
    result = result_q;
    wa     = wa_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [23:0] a = '0, b = '0;
  logic [3:0]  dst = '0;
  logic        busy, done, we, err;
  logic [23:0] result;
  logic [3:0]  wa;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MUL_DIV_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mul_div_unit #(.WIDTH(24), .ITER(24)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dst(dst),
    .busy(busy), .done(done), .result(result), .we(we), .wa(wa), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the op definitions.
  function automatic logic [23:0] ref_res(input logic [1:0] o, input logic [23:0] x, input logic [23:0] y);
    logic [47:0] p;
    p = 48'(x) * 48'(y);
    case (o)
      2'b00:   ref_res = p[23:0];
      2'b01:   ref_res = (y == 0) ? 24'hFFFFFF : x / y;
      2'b10:   ref_res = (y == 0) ? x : x % y;
      default: ref_res = 24'h0;
    endcase
  endfunction

  // Behavioural model: phase 0 idle, 1 running, 2 done.
  int          m_st = 0, m_left = 0;
  logic [23:0] m_res = '0, p_res = '0;
  logic [3:0]  m_wa = '0, p_wa = '0;
  logic        m_err = 1'b0, m_we = 1'b0, p_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0; m_left <= 0; m_res <= '0; m_wa <= '0; m_err <= 1'b0; m_we <= 1'b0;
    end else if (m_st == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_st <= 2; m_res <= p_res; m_err <= p_err; m_we <= 1'b1; m_wa <= p_wa;
      end
    end else if (start) begin
      if (op == 2'b11 || (!DIV_EN && op != 2'b00)) begin
        m_st <= 2; m_res <= '0; m_err <= 1'b1; m_we <= 1'b0; m_wa <= dst;
      end else begin
        m_st <= 1; m_left <= 24;
        p_res <= ref_res(op, a, b);
        p_err <= (op != 2'b00) && (b == 0);
        p_wa  <= dst;
      end
    end else begin
      m_st <= 0;
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    chk("busy", busy, m_st == 1);
    chk("done", done, m_st == 2);
    chk("err",  err,  m_st == 2 && m_err);
    chk("we",   we,   m_st == 2 && m_we && m_wa < 11);
    if (m_st != 1) begin
      chk("result", result, m_res);
      chk("wa", wa, m_wa);
    end
  end

  // Called on a negedge; returns how many more negedges passed before done.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: no done within 60 cycles");
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [23:0] xa, input logic [23:0] xb,
                        input logic [3:0] d, input logic [23:0] er, input logic ee, input logic ewe, input int elat);
    int w;
    start = 1'b1; op = o; a = xa; b = xb; dst = d;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; dst = 4'($urandom);
    wait_done(w);
    if (done) begin
      chk({nm, ".lat"}, w + 1, elat);
      chk({nm, ".result"}, result, er);
      chk({nm, ".err"}, err, ee);
      chk({nm, ".we"}, we, ewe);
      chk({nm, ".wa"}, wa, d);
    end
    @(negedge clk);
  endtask

  initial begin
    int w;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0); chk("rst.done", done, 0); chk("rst.we", we, 0);
    chk("rst.err", err, 0);   chk("rst.result", result, 0); chk("rst.wa", wa, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul3x5",   2'b00, 24'h000003, 24'h000005, 4'd4, 24'h00000F, 0, 1, 25);
    run_op("multrunc", 2'b00, 24'h800000, 24'h000002, 4'd1, 24'h000000, 0, 1, 25);
    run_op("mulff",    2'b00, 24'hFFFFFF, 24'hFFFFFF, 4'd2, 24'h000001, 0, 1, 25);
`ifdef MUL_DIV_UNIT_DIV_EN
    run_op("div",      2'b01, 24'd100, 24'd7, 4'd5, 24'h00000E, 0, 1, 25);
    run_op("mod",      2'b10, 24'd100, 24'd7, 4'd6, 24'h000002, 0, 1, 25);
    run_op("div0",     2'b01, 24'd5,   24'd0, 4'd7, 24'hFFFFFF, 1, 1, 25);
    run_op("mod0",     2'b10, 24'd5,   24'd0, 4'd8, 24'h000005, 1, 1, 25);
    run_op("divbig",   2'b01, 24'hFFFFFF, 24'h000010, 4'd3, 24'h0FFFFF, 0, 1, 25);
`else
    run_op("div_off",  2'b01, 24'd100, 24'd7, 4'd5, 24'h0, 1, 0, 1);
    run_op("mod_off",  2'b10, 24'd100, 24'd7, 4'd6, 24'h0, 1, 0, 1);
`endif
    run_op("op11",     2'b11, 24'd9, 24'd9, 4'd5, 24'h0, 1, 0, 1);
    run_op("mul_wa11", 2'b00, 24'd2, 24'd3, 4'd11, 24'd6, 0, 0, 25);
    run_op("mul_wa15", 2'b00, 24'd4, 24'd5, 4'd15, 24'd20, 0, 0, 25);
    run_op("mul_wa10", 2'b00, 24'd4, 24'd5, 4'd10, 24'd20, 0, 1, 25);

    // A start during RUN is ignored.
    start = 1'b1; op = 2'b00; a = 24'd7; b = 24'd6; dst = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; a = 24'd100; b = 24'd100; dst = 4'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(w);
    chk("ignore.result", result, 24'd42);
    chk("ignore.wa", wa, 4'd3);
    @(negedge clk);

    // Back-to-back: start held high through DONE.
    start = 1'b1; op = 2'b00; a = 24'd3; b = 24'd4; dst = 4'd1;
    @(negedge clk);
    wait_done(w);
    chk("b2b.first", result, 24'd12);
    @(negedge clk);
    start = 1'b0;
    wait_done(w);
    chk("b2b.gap", w + 1, 25);
    chk("b2b.second", result, 24'd12);
    @(negedge clk);

    // Reset mid-RUN at N+12.
    start = 1'b1; op = 2'b00; a = 24'd9; b = 24'd9; dst = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", busy, 0); chk("abort.done", done, 0); chk("abort.we", we, 0);
    chk("abort.err", err, 0);   chk("abort.result", result, 0); chk("abort.wa", wa, 0);
    w = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || we) w++;
    end
    chk("abort.nodone", w, 0);

    // Reset and start together: reset wins.
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 24'd1; b = 24'd1; dst = 4'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rststart.busy", busy, 0);
    @(negedge clk);
    chk("rststart.busy2", busy, 0);
    chk("rststart.done", done, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
